// File: rtl/imem_loader.sv
// Byte-stream loader for the CPU instruction memory: parses a length header,
// little-endian 32-bit words and an XOR checksum, issuing one write per word.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // state   | meaning
    // IDLE    | no session since reset
    // LEN_LO  | waiting for length byte N[7:0]
    // LEN_HI  | waiting for length byte N[15:8]
    // DATA    | assembling payload words, one write per 4 bytes
    // CHECK   | waiting for checksum byte
    // DONE    | session finished with good checksum, CPU released
    // ERROR   | session aborted, CPU still held
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [16:0] MAX_WORDS = 17'(1 << ADDR_WIDTH);

    logic [2:0]  r_state;
    logic [15:0] r_len;
    logic [16:0] r_word_idx;
    logic [1:0]  r_byte_cnt;
    logic [7:0]  r_csum;
    logic [23:0] r_buf;
    logic        r_mem_we;
    logic [31:0] r_mem_waddr;
    logic [31:0] r_mem_wdata;

    logic        w_active;
    logic        w_accept;
    logic [15:0] w_len_full;
    logic [16:0] w_idx_next;

    assign w_active   = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                        (r_state == S_DATA)   || (r_state == S_CHECK);
    assign w_accept   = byte_valid && w_active;
    assign w_len_full = {byte_data, r_len[7:0]};
    assign w_idx_next = r_word_idx + 17'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_word_idx  <= '0;
            r_byte_cnt  <= '0;
            r_csum      <= '0;
            r_buf       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state    <= S_LEN_LO;
                        r_len      <= '0;
                        r_word_idx <= '0;
                        r_byte_cnt <= '0;
                        r_csum     <= '0;
                        r_buf      <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= byte_data;
                        r_state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len <= w_len_full;
                        if ({1'b0, w_len_full} > MAX_WORDS)
                            r_state <= S_ERROR;
                        else if (w_len_full == 16'd0)
                            r_state <= S_CHECK;
                        else
                            r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_csum     <= r_csum ^ byte_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0: r_buf[7:0]   <= byte_data;
                            2'd1: r_buf[15:8]  <= byte_data;
                            2'd2: r_buf[23:16] <= byte_data;
                            default: begin
                                r_mem_we    <= 1'b1;
                                r_mem_waddr <= {13'd0, r_word_idx, 2'b00};
                                r_mem_wdata <= {byte_data, r_buf};
                                r_word_idx  <= w_idx_next;
                                if (w_idx_next == {1'b0, r_len})
                                    r_state <= S_CHECK;
                            end
                        endcase
                    end
                end
                S_CHECK: begin
                    if (w_accept)
                        r_state <= (byte_data == r_csum) ? S_DONE : S_ERROR;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign byte_ready = w_active;
    assign busy       = w_active;
    // An aborted load leaves a partial image, so the CPU stays held in ERROR.
    assign cpu_hold   = w_active || (r_state == S_ERROR);
    assign done       = (r_state == S_DONE);
    assign error      = (r_state == S_ERROR);
    assign mem_we     = r_mem_we;
    assign mem_waddr  = r_mem_waddr;
    assign mem_wdata  = r_mem_wdata;

endmodule
